pll_reconfig_sequencer: RTL and testbench
=========================================

// Module: pll_reconfig_sequencer
// PURPOSE
// Sequences run-time retuning of the reconfigurable Cyclone V video/system PLL through the
// Avalon-MM management port of the PLL reconfiguration core (the block that owns the 64-bit
// reconfig_to_pll/reconfig_from_pll buses). On request it walks a table of {address,data}
// writes, issues the start command, then supervises PLL relock and reports done/error.
// PARAMETERS
// SEL_W         2      width of mode select; table holds 2**SEL_W modes
// IDX_W         4      width of entry index; at most 2**IDX_W writes per mode
// SETTLE_CYC    64     cycles after start completes during which locked is ignored
// LOCK_TIMEOUT  100000 cycles allowed for locked to rise after settle; >=1
// PORTS
// clk               in   1      system clock (same clock as the reconfig core mgmt_clk)
// rst               in   1      synchronous active-high reset
// cfg_req           in   1      one-cycle request to apply mode cfg_sel
// cfg_sel           in   SEL_W  mode to apply; sampled only when cfg_req accepted
// busy              out  1      high from accepted request until done/error pulse
// done              out  1      one-cycle pulse: reconfig complete, PLL locked
// error             out  1      one-cycle pulse: lock timeout
// tbl_addr          out  SEL_W+IDX_W  {latched sel, entry idx} to external combinational ROM
// tbl_entry         in   39     {last[38], addr[37:32], data[31:0]}; valid same cycle
// mgmt_reset        out  1      reset to reconfig core; equals rst registered (1 cycle)
// mgmt_address      out  6      Avalon address
// mgmt_writedata    out  32     Avalon write data
// mgmt_write        out  1      Avalon write strobe
// mgmt_waitrequest  in   1      Avalon stall
// pll_locked        in   1      PLL locked (asynchronous; 2-FF synchronised internally)
// BEHAVIOUR
// Reset: state IDLE; busy/done/error/mgmt_write=0; mgmt_address/writedata=0; idx=0; mgmt_reset=1.
// Avalon rule: mgmt_write, mgmt_address, mgmt_writedata stable while mgmt_waitrequest=1; a write
//  completes on the rising clk edge where mgmt_write=1 & mgmt_waitrequest=0; mgmt_write drops next cycle.
// FSM:
//  IDLE   : cfg_req=1 -> latch sel, idx=0, busy=1, go MODE. cfg_req while busy is ignored (no queue).
//  MODE   : write addr 0x00 data 0 (waitrequest mode); on completion -> FETCH.
//  FETCH  : one cycle; register tbl_entry into addr/data/last -> WRITE.
//  WRITE  : issue write; on completion: last=1 or idx=2**IDX_W-1 -> START, else idx+1 -> FETCH.
//           idx never wraps; final index is treated as last even if last=0.
//  START  : write addr 0x02 data 1; core holds waitrequest until counters loaded; on completion
//           load settle counter = SETTLE_CYC -> SETTLE.
//  SETTLE : count down; at 0 load timer = LOCK_TIMEOUT -> LOCKW.
//  LOCKW  : synced locked=1 -> pulse done, busy=0 -> IDLE; timer reaches 0 with locked=0 ->
//           pulse error, busy=0 -> IDLE. Locked and timer expiry same cycle -> done wins.
// done/error are asserted in the cycle busy falls; a new cfg_req is accepted the following cycle.
// Per mode: 1 (MODE) + 2*N (FETCH+WRITE) + 1 (START) cycles minimum with waitrequest=0.
// rst mid-operation: next edge returns to IDLE, mgmt_write=0 immediately (transfer abandoned),
//  mgmt_reset pulses so the reconfig core also restarts; no done/error pulse.
// Counters sized ceil(log2(max+1)); no arithmetic overflow possible.
// TESTING
// 1 mode 1, 3 entries (last on 3rd), waitrequest=0, locked re-rises 10 cyc after settle -> writes
//   (0,0),(e0),(e1),(e2),(2,1) in order; done pulse at settle+10+sync latency; busy low after.
// 2 waitrequest held high 5 cyc on 2nd entry -> address/data/write stable all 5 cycles, single
//   completion, sequence otherwise identical to test 1.
// 3 locked stays 0 -> error pulse exactly LOCK_TIMEOUT cycles after SETTLE exit; no done.
// 4 table with no last bit -> exactly 16 entry writes then start write; idx does not wrap.
// 5 cfg_req asserted during WRITE with different sel -> ignored; tbl_addr keeps original sel.
// 6 rst asserted in START with waitrequest=1 -> next cycle mgmt_write=0, busy=0, IDLE; new
//   request after rst runs full sequence from MODE.

Source files
------------

// File: rtl/pll_reconfig_sequencer.sv
// Drives a table of {address,data} writes into the PLL reconfiguration core's management port,
// issues the start command, then waits out a settle window and checks for PLL relock.
module pll_reconfig_sequencer #(
  parameter int SEL_W        = 2,
  parameter int IDX_W        = 4,
  parameter int SETTLE_CYC   = 64,
  parameter int LOCK_TIMEOUT = 100000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cfg_req,
  input  logic [SEL_W-1:0]       cfg_sel,
  output logic                   busy,
  output logic                   done,
  output logic                   error,
  output logic [SEL_W+IDX_W-1:0] tbl_addr,
  input  logic [38:0]            tbl_entry,
  output logic                   mgmt_reset,
  output logic [5:0]             mgmt_address,
  output logic [31:0]            mgmt_writedata,
  output logic                   mgmt_write,
  input  logic                   mgmt_waitrequest,
  input  logic                   pll_locked
);

  localparam int CNT_MAX = (SETTLE_CYC > LOCK_TIMEOUT) ? SETTLE_CYC : LOCK_TIMEOUT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [5:0]       MODE_ADDR  = 6'h00;
  localparam logic [5:0]       START_ADDR = 6'h02;
  localparam logic [IDX_W-1:0] IDX_LAST   = {IDX_W{1'b1}};

  typedef enum logic [2:0] {IDLE, MODE, FETCH, WRITE, START, SETTLE, LOCKW} state_t;

  state_t             state, state_d;
  logic [SEL_W-1:0]   sel, sel_d;
  logic [IDX_W-1:0]   idx, idx_d;
  logic               ent_last, ent_last_d;
  logic [CNT_W-1:0]   cnt, cnt_d;
  logic               wr_d, busy_d, done_d, error_d;
  logic [5:0]         addr_d;
  logic [31:0]        data_d;
  logic               lock_meta, lock_sync;
  logic               xfer_done;

  assign tbl_addr  = {sel, idx};
  assign xfer_done = mgmt_write & ~mgmt_waitrequest;

  // pll_locked comes from the PLL's own clock domain; mgmt_reset follows rst one cycle late.
  always_ff @(posedge clk) begin
    mgmt_reset <= rst;
    if (rst) begin
      lock_meta <= 1'b0;
      lock_sync <= 1'b0;
    end else begin
      lock_meta <= pll_locked;
      lock_sync <= lock_meta;
    end
  end

  // NOTE: every register here is updated with <= so all of them see the same pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      sel            <= '0;
      idx            <= '0;
      ent_last       <= 1'b0;
      cnt            <= '0;
      mgmt_write     <= 1'b0;
      mgmt_address   <= '0;
      mgmt_writedata <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      error          <= 1'b0;
    end else begin
      state          <= state_d;
      sel            <= sel_d;
      idx            <= idx_d;
      ent_last       <= ent_last_d;
      cnt            <= cnt_d;
      mgmt_write     <= wr_d;
      mgmt_address   <= addr_d;
      mgmt_writedata <= data_d;
      busy           <= busy_d;
      done           <= done_d;
      error          <= error_d;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_d    = state;
    sel_d      = sel;
    idx_d      = idx;
    ent_last_d = ent_last;
    cnt_d      = cnt;
    wr_d       = mgmt_write;
    addr_d     = mgmt_address;
    data_d     = mgmt_writedata;
    busy_d     = busy;
    done_d     = 1'b0;
    error_d    = 1'b0;

    case (state)
      IDLE: begin
        if (cfg_req) begin
          sel_d   = cfg_sel;
          idx_d   = '0;
          busy_d  = 1'b1;
          wr_d    = 1'b1;
          addr_d  = MODE_ADDR;
          data_d  = 32'd0;
          state_d = MODE;
        end
      end
      MODE: begin
        if (xfer_done) begin
          wr_d    = 1'b0;
          state_d = FETCH;
        end
      end
      FETCH: begin
        ent_last_d = tbl_entry[38];
        addr_d     = tbl_entry[37:32];
        data_d     = tbl_entry[31:0];
        wr_d       = 1'b1;
        state_d    = WRITE;
      end
      WRITE: begin
        if (xfer_done) begin
          // The final index ends the table even without its last bit, so idx never wraps.
          if (ent_last || idx == IDX_LAST) begin
            wr_d    = 1'b1;
            addr_d  = START_ADDR;
            data_d  = 32'd1;
            state_d = START;
          end else begin
            wr_d    = 1'b0;
            idx_d   = idx + IDX_W'(1);
            state_d = FETCH;
          end
        end
      end
      START: begin
        if (xfer_done) begin
          wr_d    = 1'b0;
          cnt_d   = CNT_W'(SETTLE_CYC);
          state_d = SETTLE;
        end
      end
      SETTLE: begin
        if (cnt <= CNT_W'(1)) begin
          cnt_d   = CNT_W'(LOCK_TIMEOUT);
          state_d = LOCKW;
        end else begin
          cnt_d = cnt - CNT_W'(1);
        end
      end
      LOCKW: begin
        // Lock is tested ahead of the timer so a simultaneous expiry still reports done.
        if (lock_sync) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else if (cnt <= CNT_W'(1)) begin
          error_d = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt - CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_pll_reconfig_sequencer.sv
// Bench for pll_reconfig_sequencer: random tables per mode, an Avalon slave responder that
// records completed writes, and a reference model of write order and done/error timing.
module tb_pll_reconfig_sequencer;

  localparam int SEL_W = 2;
  localparam int IDX_W = 4;
  localparam int SC    = 8;
  localparam int LT    = 20;
  localparam int AW    = SEL_W + IDX_W;
  localparam int NENT  = 1 << IDX_W;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             cfg_req = 1'b0;
  logic [SEL_W-1:0] cfg_sel = '0;
  logic             busy, done, error;
  logic [AW-1:0]    tbl_addr;
  logic [38:0]      tbl_entry;
  logic             mgmt_reset;
  logic [5:0]       mgmt_address;
  logic [31:0]      mgmt_writedata;
  logic             mgmt_write;
  logic             mgmt_waitrequest = 1'b0;
  logic             pll_locked = 1'b0;

  logic [38:0] rom [0:(1<<AW)-1];
  assign tbl_entry = rom[tbl_addr];

  pll_reconfig_sequencer #(
    .SEL_W(SEL_W), .IDX_W(IDX_W), .SETTLE_CYC(SC), .LOCK_TIMEOUT(LT)
  ) dut (
    .clk(clk), .rst(rst), .cfg_req(cfg_req), .cfg_sel(cfg_sel),
    .busy(busy), .done(done), .error(error),
    .tbl_addr(tbl_addr), .tbl_entry(tbl_entry),
    .mgmt_reset(mgmt_reset), .mgmt_address(mgmt_address),
    .mgmt_writedata(mgmt_writedata), .mgmt_write(mgmt_write),
    .mgmt_waitrequest(mgmt_waitrequest), .pll_locked(pll_locked)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  typedef struct {
    int          edge_n;
    logic [5:0]  a;
    logic [31:0] d;
  } wr_t;

  wr_t wr_q[$];
  int  done_edges[$];
  int  err_edges[$];
  int  stall_at   = -1;
  int  stall_left = 0;
  logic        holding = 1'b0;
  logic [5:0]  hold_a;
  logic [31:0] hold_d;

  // Avalon slave: decides waitrequest for the coming edge and logs writes that will complete.
  initial forever begin
    @(posedge clk); #1;
    if (done) begin
      done_edges.push_back(cyc);
      check("done_with_busy_low", busy, 0);
    end
    if (error) err_edges.push_back(cyc);
    if (rst) begin
      mgmt_waitrequest = 1'b0;
      stall_left = 0;
      holding = 1'b0;
    end else begin
      if (holding) begin
        check("hold_write", mgmt_write, 1);
        check("hold_addr", mgmt_address, hold_a);
        check("hold_data", mgmt_writedata, hold_d);
      end
      if (mgmt_write && wr_q.size() == stall_at && stall_left > 0) begin
        mgmt_waitrequest = 1'b1;
        stall_left--;
        if (!holding) begin
          holding = 1'b1;
          hold_a = mgmt_address;
          hold_d = mgmt_writedata;
        end
      end else begin
        mgmt_waitrequest = 1'b0;
        holding = 1'b0;
        if (mgmt_write) wr_q.push_back('{cyc + 1, mgmt_address, mgmt_writedata});
      end
    end
  end

  function automatic int ridx(input int s, input int i);
    return (s << IDX_W) + i;
  endfunction

  // Entries written for a mode: up to and including the first last bit, else the whole table.
  function automatic int model_len(input int s);
    for (int i = 0; i < NENT; i++)
      if (rom[ridx(s, i)][38]) return i + 1;
    return NENT;
  endfunction

  function automatic int first_or_neg(input int q[$]);
    return (q.size() > 0) ? q[0] : -1;
  endfunction

  task automatic fill(input int s, input int last_pos);
    for (int i = 0; i < NENT; i++)
      rom[ridx(s, i)] = {1'(i == last_pos), 6'($urandom), 32'($urandom)};
  endtask

  task automatic wait_edge(input int e);
    while (cyc < e) begin
      @(posedge clk); #2;
    end
  endtask

  // Returns the edge number at which the request is sampled.
  task automatic start_req(input int s, output int r);
    wr_q.delete();
    done_edges.delete();
    err_edges.delete();
    @(posedge clk); #2;
    cfg_sel = SEL_W'(s);
    cfg_req = 1'b1;
    r = cyc + 1;
    @(posedge clk); #2;
    cfg_req = 1'b0;
    cfg_sel = SEL_W'(s + 1);
    check("busy_after_req", busy, 1);
  endtask

  task automatic wait_end(input int budget);
    int k = 0;
    while (done_edges.size() + err_edges.size() == 0 && k < budget) begin
      @(posedge clk); #2;
      k++;
    end
    check("end_within_budget", k < budget, 1);
    repeat (5) begin
      @(posedge clk); #2;
    end
    check("busy_low_after_end", busy, 0);
  endtask

  // Expected: (0,0), each entry, (2,1); completions every 2 cycles after the mode write.
  task automatic check_writes(input int s, input int r, input int st_idx, input int st_n);
    int n = model_len(s);
    check("wr_count", wr_q.size(), n + 2);
    for (int i = 0; i < n + 2 && i < wr_q.size(); i++) begin
      logic [5:0]  ea;
      logic [31:0] ed;
      int          ee;
      if (i == 0) begin
        ea = 6'h00; ed = 32'd0; ee = r + 1;
      end else if (i <= n) begin
        ea = rom[ridx(s, i - 1)][37:32];
        ed = rom[ridx(s, i - 1)][31:0];
        ee = r + 1 + 2 * i;
      end else begin
        ea = 6'h02; ed = 32'd1; ee = r + 2 * n + 2;
      end
      if (st_idx >= 0 && i >= st_idx) ee += st_n;
      check($sformatf("wr%0d_addr", i), wr_q[i].a, ea);
      check($sformatf("wr%0d_data", i), wr_q[i].d, ed);
      check($sformatf("wr%0d_edge", i), wr_q[i].edge_n, ee);
    end
  endtask

  initial begin
    int r, n, se, off;
    for (int m = 0; m < (1 << SEL_W); m++) fill(m, int'($urandom_range(0, NENT - 1)));

    repeat (3) @(posedge clk);
    #2;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    check("rst_write", mgmt_write, 0);
    check("rst_addr", mgmt_address, 0);
    check("rst_data", mgmt_writedata, 0);
    check("rst_mgmt_reset", mgmt_reset, 1);
    check("rst_tbl_addr", tbl_addr, 0);
    rst = 1'b0;
    @(posedge clk); #2;
    check("mgmt_reset_released", mgmt_reset, 0);

    // Three entries, locked rises 10 cycles after settle.
    fill(1, 2);
    pll_locked = 1'b0;
    start_req(1, r);
    n  = model_len(1);
    se = r + 2 * n + 2;
    wait_edge(se + SC + 10);
    pll_locked = 1'b1;
    wait_end(40);
    check_writes(1, r, -1, 0);
    check("t1_done_count", done_edges.size(), 1);
    check("t1_done_edge", first_or_neg(done_edges), se + SC + 13);
    check("t1_err_count", err_edges.size(), 0);

    // Same table, second entry stalled 5 cycles; locked held high across settle.
    stall_at = 2;
    stall_left = 5;
    start_req(1, r);
    se = r + 2 * n + 2 + 5;
    wait_end(100);
    check_writes(1, r, 2, 5);
    check("t2_done_edge", first_or_neg(done_edges), se + SC + 1);
    check("t2_err_count", err_edges.size(), 0);
    stall_at = -1;

    // Locked never rises: error exactly LT cycles after settle ends.
    n = int'($urandom_range(1, 6));
    fill(2, n - 1);
    pll_locked = 1'b0;
    start_req(2, r);
    se = r + 2 * n + 2;
    wait_end(2 * n + SC + LT + 20);
    check_writes(2, r, -1, 0);
    check("t3_err_count", err_edges.size(), 1);
    check("t3_err_edge", first_or_neg(err_edges), se + SC + LT);
    check("t3_done_count", done_edges.size(), 0);

    // No last bit: all 16 entries; lock arrives on the timer's final cycle, so done wins.
    fill(3, -1);
    start_req(3, r);
    se  = r + 2 * NENT + 2;
    off = LT - 3;
    wait_edge(se + SC + off);
    pll_locked = 1'b1;
    wait_end(100);
    check_writes(3, r, -1, 0);
    check("t4_done_edge", first_or_neg(done_edges), se + SC + LT);
    check("t4_err_count", err_edges.size(), 0);

    // Request with another sel during a WRITE is ignored.
    fill(0, 3);
    start_req(0, r);
    n  = model_len(0);
    se = r + 2 * n + 2;
    wait_edge(r + 4);
    cfg_sel = SEL_W'(3);
    cfg_req = 1'b1;
    @(posedge clk); #2;
    cfg_req = 1'b0;
    check("t5_tbl_addr", tbl_addr, 6'h02);
    wait_end(60);
    check_writes(0, r, -1, 0);
    check("t5_done_edge", first_or_neg(done_edges), se + SC + 1);
    repeat (10) @(posedge clk);
    #2;
    check("t5_no_rerun_busy", busy, 0);
    check("t5_no_rerun_writes", wr_q.size(), n + 2);

    // Reset while the start write is stalled, then a clean rerun.
    n = model_len(1);
    stall_at = n + 1;
    stall_left = 1000;
    start_req(1, r);
    wait_edge(r + 2 * n + 3);
    check("t6_start_pending", mgmt_write, 1);
    check("t6_start_addr", mgmt_address, 6'h02);
    rst = 1'b1;
    @(posedge clk); #2;
    check("t6_write_dropped", mgmt_write, 0);
    check("t6_busy_dropped", busy, 0);
    check("t6_addr_cleared", mgmt_address, 0);
    check("t6_mgmt_reset_hi", mgmt_reset, 1);
    rst = 1'b0;
    stall_at = -1;
    @(posedge clk); #2;
    check("t6_mgmt_reset_lo", mgmt_reset, 0);
    repeat (5) @(posedge clk);
    #2;
    check("t6_no_pulse", done_edges.size() + err_edges.size(), 0);
    start_req(1, r);
    se = r + 2 * n + 2;
    wait_end(60);
    check_writes(1, r, -1, 0);
    check("t6_done_edge", first_or_neg(done_edges), se + SC + 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
